// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared LED matrix geometry and scan state encoding
package display_pkg;

    // Geometry shared with full_display_decoder.
    localparam int COLUNE_SIZE   = 7;
    localparam int TOTAL_COLUNES = 5;
    localparam int DATA_WIDTH    = COLUNE_SIZE * TOTAL_COLUNES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// rtl/scan_dwell_timer.sv - loadable down-counter pacing column dwell and blank
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : strobe, count takes load_value on this edge
//   load_value   : value loaded on strobe
//   zero         : count has reached zero (counter holds there)
module scan_dwell_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - column-multiplexed LED matrix driver with blanking
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : scanning runs while high (sampled at frame boundaries)
//   display_data  : packed frame, column c at [c*COLUNE_SIZE +: COLUNE_SIZE]
//   column_select : active-low column enables, at most one low
//   row_data      : active-low row drive
//   frame_done    : one-cycle pulse after the last column has been shown
module matrix_column_scanner #(
    parameter int DATA_WIDTH    = display_pkg::DATA_WIDTH,
    parameter int COLUNE_SIZE   = display_pkg::COLUNE_SIZE,
    parameter int TOTAL_COLUNES = display_pkg::TOTAL_COLUNES,
    parameter int DWELL_CYCLES  = 1000,
    parameter int BLANK_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    display_data,
    output logic [TOTAL_COLUNES-1:0] column_select,
    output logic [COLUNE_SIZE-1:0]   row_data,
    output logic                     frame_done
);

    import display_pkg::*;

    localparam int MAX_COUNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW        = $clog2(MAX_COUNT + 1);
    localparam int CW        = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;

    if (DATA_WIDTH != COLUNE_SIZE * TOTAL_COLUNES || DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("matrix_column_scanner: inconsistent geometry or zero dwell/blank count");
    end

    scan_state_t          state;
    logic [CW-1:0]        col_idx;
    logic [CW-1:0]        next_col;
    logic [DATA_WIDTH-1:0] frame_buffer;
    logic                 last_col;
    logic                 timer_zero;
    logic                 timer_load;
    logic [TW-1:0]        timer_value;

    assign next_col = col_idx + CW'(1);
    assign last_col = (col_idx == CW'(TOTAL_COLUNES - 1));

    function automatic logic [TOTAL_COLUNES-1:0] col_enable(input logic [CW-1:0] idx);
        logic [TOTAL_COLUNES-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    // One timer serves both phases: leaving DRIVE arms the blank count,
    // everything else that starts a column arms the dwell count.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TW'(DWELL_CYCLES - 1);
        case (state)
            LOAD:  timer_load = 1'b1;
            DRIVE: begin
                timer_load  = timer_zero;
                timer_value = TW'(BLANK_CYCLES - 1);
            end
            BLANK: timer_load = timer_zero && !last_col;
            default: ;
        endcase
    end

    scan_dwell_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Outputs are computed for the state being entered, so they switch on
    // the same edge as the state register without a combinational path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            col_idx       <= '0;
            frame_buffer  <= '0;
            column_select <= '1;
            row_data      <= '1;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    frame_buffer  <= display_data;
                    col_idx       <= '0;
                    column_select <= col_enable('0);
                    row_data      <= ~display_data[COLUNE_SIZE-1:0];
                    state         <= DRIVE;
                end
                DRIVE: begin
                    if (timer_zero) begin
                        column_select <= '1;
                        row_data      <= '1;
                        state         <= BLANK;
                    end
                end
                BLANK: begin
                    if (timer_zero) begin
                        if (!last_col) begin
                            col_idx       <= next_col;
                            column_select <= col_enable(next_col);
                            row_data      <= ~frame_buffer[int'(next_col)*COLUNE_SIZE +: COLUNE_SIZE];
                            state         <= DRIVE;
                        end else begin
                            // Frame boundary: the only point where a new frame may be taken.
                            frame_done <= 1'b1;
                            state      <= enable ? LOAD : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - directed self-checking bench for matrix_column_scanner
module tb_matrix_column_scanner;
    import display_pkg::*;

    localparam int DW = 3;
    localparam int BW = 1;
    localparam int PERIOD = 1 + TOTAL_COLUNES * (DW + BW);

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     enable = 1'b0;
    logic [DATA_WIDTH-1:0]    display_data = '0;
    logic [TOTAL_COLUNES-1:0] column_select;
    logic [COLUNE_SIZE-1:0]   row_data;
    logic                     frame_done;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_fd = -1;
    bit period_on = 1'b0;
    logic [TOTAL_COLUNES-1:0] prev_cs = '1;

    always #5 clk = ~clk;

    matrix_column_scanner #(
        .DATA_WIDTH    (DATA_WIDTH),
        .COLUNE_SIZE   (COLUNE_SIZE),
        .TOTAL_COLUNES (TOTAL_COLUNES),
        .DWELL_CYCLES  (DW),
        .BLANK_CYCLES  (BW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .display_data  (display_data),
        .column_select (column_select),
        .row_data      (row_data),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] cs, input logic [6:0] rd, input logic fd);
        chk({tag, "_cs"}, 32'(column_select), 32'(cs));
        chk({tag, "_rd"}, 32'(row_data), 32'(rd));
        chk({tag, "_fd"}, 32'(frame_done), 32'(fd));
    endtask

    // Advance one edge and check the always-on invariants.
    task automatic tick();
        logic ok;
        @(posedge clk);
        #1;
        cyc++;
        chk("one_hot", 32'($countones(~column_select) <= 1), 32'd1);
        ok = (prev_cs == 5'h1F) || (column_select == 5'h1F) || (column_select == prev_cs);
        chk("blank_between", 32'(ok), 32'd1);
        prev_cs = column_select;
        if (frame_done === 1'b1) begin
            if (period_on && last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(PERIOD));
            last_fd = cyc;
        end
    endtask

    // Called one cycle into LOAD; walks the whole frame up to the frame_done cycle.
    task automatic expect_frame(input logic [34:0] data, input int chg_col,
                                input logic [34:0] chg_data, input int drop_col);
        logic [4:0] cs;
        logic [6:0] rd;
        for (int c = 0; c < TOTAL_COLUNES; c++) begin
            cs = 5'h1F;
            cs[c] = 1'b0;
            rd = ~data[c*7 +: 7];
            for (int d = 0; d < DW; d++) begin
                tick();
                expect_out($sformatf("col%0d_drive%0d", c, d), cs, rd, 1'b0);
                if (d == 0 && c == chg_col) display_data = chg_data;
                if (d == 0 && c == drop_col) enable = 1'b0;
            end
            for (int b = 0; b < BW; b++) begin
                tick();
                expect_out($sformatf("col%0d_blank", c), 5'h1F, 7'h7F, 1'b0);
            end
        end
        tick();
        expect_out("frame_done", 5'h1F, 7'h7F, 1'b1);
    endtask

    logic [34:0] data_a;
    logic [34:0] data_b;
    logic [34:0] frames [6];

    initial begin
        data_a = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
        data_b = {7'h55, 7'h2A, 7'h7F, 7'h00, 7'h3C};
        frames[0] = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
        frames[1] = {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F};
        frames[2] = {7'h01, 7'h40, 7'h01, 7'h40, 7'h01};
        frames[3] = {7'h6B, 7'h14, 7'h2D, 7'h52, 7'h0F};
        frames[4] = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        frames[5] = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};

        // Reset held low
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 5'h1F, 7'h7F, 1'b0);
        reset_n = 1'b1;
        tick();
        expect_out("idle_after_reset", 5'h1F, 7'h7F, 1'b0);

        // Asynchronous reset in the middle of DRIVE
        display_data = data_a;
        enable = 1'b1;
        tick();
        expect_out("load_cycle", 5'h1F, 7'h7F, 1'b0);
        enable = 1'b0;
        tick();
        expect_out("pre_reset_drive", 5'b11110, 7'h7E, 1'b0);
        #3 reset_n = 1'b0;
        #1 expect_out("async_reset", 5'h1F, 7'h7F, 1'b0);
        #2 reset_n = 1'b1;
        tick();
        expect_out("restart_idle", 5'h1F, 7'h7F, 1'b0);

        // Single frame from a one-cycle enable pulse
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_frame(data_a, -1, '0, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("idle_after_single", 5'h1F, 7'h7F, 1'b0);
        end

        // Data change mid-frame is held off until the next LOAD
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_frame(data_a, 2, {35{1'b1}}, -1);
        tick();
        expect_out("idle_between", 5'h1F, 7'h7F, 1'b0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_frame({35{1'b1}}, -1, '0, -1);

        // Enable dropped during column 1: frame still completes, then stays idle
        display_data = data_b;
        tick();
        enable = 1'b1;
        tick();
        expect_frame(data_b, -1, '0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out("idle_after_drop", 5'h1F, 7'h7F, 1'b0);
        end

        // Continuous scanning with new data presented during each LOAD cycle
        display_data = frames[0];
        enable = 1'b1;
        period_on = 1'b1;
        last_fd = -1;
        tick();
        for (int f = 0; f < 6; f++) begin
            if (f == 5) enable = 1'b0;
            expect_frame(frames[f], -1, '0, -1);
            if (f < 5) display_data = frames[f+1];
        end
        period_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("idle_final", 5'h1F, 7'h7F, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
